// File: rtl/collision_scan.sv
// rtl/collision_scan.sv - sequential sprite collision scanner, one pair per clock.
// Optional pair-log FIFO compiled in with COLLISION_PAIR_LOG_EN.
module collision_scan #(
  parameter int N_MOBILE  = 15,
  parameter int N_FIXED   = 17,
  parameter int HIT_SIZE  = 20,
  parameter int LOG_DEPTH = 16,
  localparam int MAX_N = (N_MOBILE > N_FIXED) ? N_MOBILE : N_FIXED,
  localparam int IDX_W = $clog2(MAX_N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mod_enable,
  input  logic [32*N_MOBILE-1:0]  s_mobile,
  input  logic [32*N_FIXED-1:0]   s_fixed,
  output logic [2*N_MOBILE-1:0]   flags,
  output logic                    busy,
  output logic                    done,
  output logic                    log_valid,
  output logic [2*IDX_W:0]        log_data,
  input  logic                    log_ready,
  output logic                    log_ovf
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SCAN_MM = 3'd2;
  localparam logic [2:0] ST_SCAN_MF = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

  localparam logic [IDX_W-1:0] M_LAST  = IDX_W'(N_MOBILE - 1);
  localparam logic [IDX_W-1:0] M_LAST2 = IDX_W'(N_MOBILE - 2);
  localparam logic [IDX_W-1:0] F_LAST  = IDX_W'(N_FIXED - 1);
  localparam logic [10:0]      HIT_W   = 11'(HIT_SIZE);

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      i_q, i_d, j_q, j_d;
  logic [2*N_MOBILE-1:0] shadow_q, shadow_d;
  logic [2*N_MOBILE-1:0] flags_q, flags_d;
  logic                  done_q, done_d;

  logic [31:0] mob_q [N_MOBILE];
  logic [31:0] fix_q [N_FIXED];
  logic [31:0] a_w, b_w;
  logic [10:0] dx, dy, adx, ady;
  logic        hit;
  logic        load_en;
  logic [N_MOBILE-1:0] i_oh, j_oh;
  logic        unused_fields;

  assign load_en = (state_q == ST_LOAD) && mod_enable;

  // Snapshot carries no reset: it is always rewritten at LOAD before use.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < N_MOBILE; k++) mob_q[k] <= s_mobile[32*k +: 32];
      for (int k = 0; k < N_FIXED; k++)  fix_q[k] <= s_fixed[32*k +: 32];
    end
  end

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int k = 0; k < N_MOBILE; k++) begin
      if (i_q == IDX_W'(k)) a_w = mob_q[k];
      if ((state_q == ST_SCAN_MM) && (j_q == IDX_W'(k))) b_w = mob_q[k];
    end
    for (int k = 0; k < N_FIXED; k++) begin
      if ((state_q == ST_SCAN_MF) && (j_q == IDX_W'(k))) b_w = fix_q[k];
    end
  end

  // 11-bit differences of zero-extended coordinates cannot wrap.
  assign dx  = {1'b0, a_w[28:19]} - {1'b0, b_w[28:19]};
  assign dy  = {1'b0, a_w[18:9]}  - {1'b0, b_w[18:9]};
  assign adx = dx[10] ? (~dx + 11'd1) : dx;
  assign ady = dy[10] ? (~dy + 11'd1) : dy;
  assign hit = a_w[29] && b_w[29] && (adx < HIT_W) && (ady < HIT_W);

  assign i_oh = N_MOBILE'(1) << i_q;
  assign j_oh = N_MOBILE'(1) << j_q;
  assign unused_fields = ^{a_w[31:30], a_w[8:0], b_w[31:30], b_w[8:0]};

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (mod_enable) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!mod_enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SCAN_MM;
          i_d      = '0;
          j_d      = IDX_W'(1);
          shadow_d = '0;
        end
      end
      ST_SCAN_MM: begin
        if (!mod_enable) begin
          state_d = ST_IDLE;
        end else begin
          if (hit) shadow_d = shadow_q | {{N_MOBILE{1'b0}}, i_oh | j_oh};
          if (j_q == M_LAST) begin
            if (i_q == M_LAST2) begin
              state_d = ST_SCAN_MF;
              i_d     = '0;
              j_d     = '0;
            end else begin
              i_d = i_q + IDX_W'(1);
              j_d = i_q + IDX_W'(2);
            end
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
      end
      ST_SCAN_MF: begin
        if (!mod_enable) begin
          state_d = ST_IDLE;
        end else begin
          if (hit) shadow_d = shadow_q | {i_oh, {N_MOBILE{1'b0}}};
          if (j_q == F_LAST) begin
            j_d = '0;
            if (i_q == M_LAST) state_d = ST_COMMIT;
            else               i_d = i_q + IDX_W'(1);
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        flags_d = shadow_q;
        done_d  = 1'b1;
        state_d = mod_enable ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      shadow_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign flags = flags_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef COLLISION_PAIR_LOG_EN
  localparam int AW = $clog2(LOG_DEPTH);

  logic [2*IDX_W:0] mem_q [LOG_DEPTH];
  logic [AW:0]      wr_q, rd_q, count;
  logic             ovf_q, full, empty, push, pop;

  assign count = wr_q - rd_q;
  assign full  = (count == (AW+1)'(LOG_DEPTH));
  assign empty = (wr_q == rd_q);
  assign push  = hit && mod_enable && ((state_q == ST_SCAN_MM) || (state_q == ST_SCAN_MF));
  assign pop   = log_ready && !empty;

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= {(state_q == ST_SCAN_MF), i_q, j_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push && !full) wr_q <= wr_q + (AW+1)'(1);
      if (pop)           rd_q <= rd_q + (AW+1)'(1);
      if (load_en)             ovf_q <= 1'b0;
      else if (push && full)   ovf_q <= 1'b1;
    end
  end

  assign log_valid = !empty;
  assign log_data  = mem_q[rd_q[AW-1:0]];
  assign log_ovf   = ovf_q;
`else
  logic unused_log;
  assign unused_log = log_ready ^ LOG_DEPTH[0];
  assign log_valid  = 1'b0;
  assign log_data   = '0;
  assign log_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_collision_scan.sv
// tb/tb_collision_scan.sv - self-checking bench for collision_scan against a pair-list model.
module tb_collision_scan;
  localparam int NM = 15;
  localparam int NF = 17;
  localparam int HS = 20;
  localparam int LD = 2;
  localparam int IW = $clog2((NM > NF) ? NM : NF);
  localparam int P  = NM * (NM - 1) / 2 + NM * NF;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mod_enable = 1'b0;
  logic               log_ready = 1'b0;
  logic [32*NM-1:0]   s_mobile = '0;
  logic [32*NF-1:0]   s_fixed = '0;
  logic [2*NM-1:0]    flags;
  logic               busy, done, log_valid, log_ovf;
  logic [2*IW:0]      log_data;

  collision_scan #(.N_MOBILE(NM), .N_FIXED(NF), .HIT_SIZE(HS), .LOG_DEPTH(LD)) dut (
    .clk(clk), .reset(reset), .mod_enable(mod_enable),
    .s_mobile(s_mobile), .s_fixed(s_fixed),
    .flags(flags), .busy(busy), .done(done),
    .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready), .log_ovf(log_ovf)
  );

  always #20 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0]   mob [NM];
  logic [31:0]   fix [NF];
  logic [2*IW:0] q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] spr(input int x, input int y);
    return {2'b00, 1'b1, 10'(x), 10'(y), 9'h0};
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit pair_hit(input logic [31:0] a, input logic [31:0] b);
    return a[29] && b[29] &&
           absdiff(int'(a[28:19]), int'(b[28:19])) < HS &&
           absdiff(int'(a[18:9]),  int'(b[18:9]))  < HS;
  endfunction

  task automatic clear_sprites();
    for (int k = 0; k < NM; k++) mob[k] = '0;
    for (int k = 0; k < NF; k++) fix[k] = '0;
  endtask

  task automatic apply();
    for (int k = 0; k < NM; k++) s_mobile[32*k +: 32] = mob[k];
    for (int k = 0; k < NF; k++) s_fixed[32*k +: 32]  = fix[k];
  endtask

  task automatic wait_done(output int n, output bit got);
    n = 0;
    got = 0;
    while (!got && n < 1000) begin
      @(posedge clk); #1;
      if (done) got = 1;
      else n++;
    end
  endtask

  // Computes expected flags and log contents for the current sprites, runs one
  // scan from IDLE and checks latency, flags, stability and log outputs.
  task automatic run_scan(input string tag);
    logic [2*NM-1:0] exp_flags;
    logic [2*NM-1:0] prev;
    bit ovf_exp, got, stable;
    int n;
    exp_flags = '0;
    ovf_exp = 0;
    for (int i = 0; i < NM; i++)
      for (int j = i + 1; j < NM; j++)
        if (pair_hit(mob[i], mob[j])) begin
          exp_flags[i] = 1'b1;
          exp_flags[j] = 1'b1;
`ifdef COLLISION_PAIR_LOG_EN
          if (q.size() < LD) q.push_back({1'b0, IW'(i), IW'(j)});
          else ovf_exp = 1;
`endif
        end
    for (int i = 0; i < NM; i++)
      for (int j = 0; j < NF; j++)
        if (pair_hit(mob[i], fix[j])) begin
          exp_flags[NM + i] = 1'b1;
`ifdef COLLISION_PAIR_LOG_EN
          if (q.size() < LD) q.push_back({1'b1, IW'(i), IW'(j)});
          else ovf_exp = 1;
`endif
        end
    apply();
    prev = flags;
    stable = 1;
    mod_enable = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 1000) begin
      @(posedge clk); #1;
      if (done) got = 1;
      else begin
        if (flags !== prev) stable = 0;
        if (n == 10) check({tag, ".busy"}, 64'(busy), 64'd1);
        n++;
      end
    end
    check({tag, ".done_seen"}, 64'(got), 64'd1);
    check({tag, ".latency"}, 64'(n), 64'(P + 2));
    check({tag, ".flags"}, 64'(flags), 64'(exp_flags));
    check({tag, ".stable"}, 64'(stable), 64'd1);
    check({tag, ".log_ovf"}, 64'(log_ovf), 64'(ovf_exp));
    check({tag, ".log_valid"}, 64'(log_valid), 64'(q.size() != 0));
    if (q.size() != 0) check({tag, ".log_head"}, 64'(log_data), 64'(q[0]));
    mod_enable = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n, n2;
    bit got, saw_done;
    logic [2*NM-1:0] prev;

    // Reset state
    #5 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.flags", 64'(flags), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.log_valid", 64'(log_valid), 64'd0);
    check("rst.log_ovf", 64'(log_ovf), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Overlapping pair of mobiles
    clear_sprites();
    mob[0] = spr(110, 110);
    mob[1] = spr(120, 120);
    run_scan("pairA");
    check("pairA.const", 64'(flags), 64'h3);

    // Two mobiles and one fixed sprite
    clear_sprites();
    mob[3] = spr(300, 300);
    mob[4] = spr(310, 310);
    fix[2] = spr(305, 302);
    run_scan("pairB");
    check("pairB.const", 64'(flags), 64'h000C0018);

`ifdef COLLISION_PAIR_LOG_EN
    check("log.first_pop", 64'(log_data), 64'h1);
`endif
    // Drain the log in order
    for (int k = 0; k < LD + 2 && q.size() != 0; k++) begin
      check("log.valid", 64'(log_valid), 64'd1);
      check("log.data", 64'(log_data), 64'(q.pop_front()));
      log_ready = 1'b1;
      @(posedge clk); #1;
      log_ready = 1'b0;
    end
    check("log.empty", 64'(log_valid), 64'd0);

    // Hitbox boundary: distance equal to HIT_SIZE misses, one less hits
    clear_sprites();
    mob[0] = spr(100, 100);
    mob[1] = spr(120, 100);
    run_scan("edge20");
    check("edge20.const", 64'(flags), 64'h0);
    mob[1] = spr(119, 100);
    run_scan("edge19");
    check("edge19.const", 64'(flags), 64'h3);
    mob[1] = spr(100, 81);
    run_scan("edgey19");
    mob[1] = spr(119, 100) & ~32'(1 << 29);
    run_scan("inactive");

    // Randomised clusters
    for (int r = 0; r < 4; r++) begin
      clear_sprites();
      for (int k = 0; k < NM; k++)
        if ($urandom_range(0, 3) != 0) mob[k] = spr($urandom_range(100, 180), $urandom_range(100, 180));
      for (int k = 0; k < NF; k++)
        if ($urandom_range(0, 3) != 0) fix[k] = spr($urandom_range(100, 180), $urandom_range(100, 180));
      run_scan($sformatf("rand%0d", r));
    end

    // Back-to-back scan period
    clear_sprites();
    mob[0] = spr(110, 110);
    mob[1] = spr(120, 120);
    apply();
    mod_enable = 1'b1;
    wait_done(n, got);
    check("b2b.first", 64'(got), 64'd1);
    wait_done(n2, got);
    check("b2b.second", 64'(got), 64'd1);
    check("b2b.period", 64'(n2 + 1), 64'(P + 2));
    check("b2b.flags", 64'(flags), 64'h3);
    mod_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Abort mid-scan: no done, flags keep last committed value
    clear_sprites();
    mob[3] = spr(300, 300);
    mob[4] = spr(310, 310);
    apply();
    prev = flags;
    saw_done = 0;
    mod_enable = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    mod_enable = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("abort.no_done", 64'(saw_done), 64'd0);
    check("abort.flags", 64'(flags), 64'(prev));
    check("abort.busy", 64'(busy), 64'd0);

    // Asynchronous reset during a scan
    mod_enable = 1'b1;
    repeat (50) @(posedge clk);
    #10 reset = 1'b0;
    #1;
    check("rstmid.flags", 64'(flags), 64'd0);
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.done", 64'(done), 64'd0);
    check("rstmid.log_valid", 64'(log_valid), 64'd0);
    check("rstmid.log_ovf", 64'(log_ovf), 64'd0);
    @(posedge clk); #1;
    mod_enable = 1'b0;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;

    // Recovery after reset
    clear_sprites();
    mob[0] = spr(110, 110);
    mob[1] = spr(120, 120);
    run_scan("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
